// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 scan-code decoder driving lowclk period, pause toggle and a 4-deep direction FIFO
// KBD_WASD_EN additionally maps WASD make codes to directions
module kbd_ctrl #(
    parameter logic [31:0] PERIOD_BASE = 32'h0000_0fff,
    parameter int          RESET_LEVEL = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  kdata,
    input  logic        kvalid,
    output logic [31:0] period,
    output logic [1:0]  cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        paused,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t state, nstate;
    logic [2:0] level, nlevel, count;
    logic [1:0] wp, rp, dir;
    logic [3:0][1:0] mem;
    logic dir_hit, inc, dec, tog, push, pop, full, accept;
    always_comb begin
        nstate = state;
        dir_hit = 1'b0;
        dir = 2'd0;
        inc = 1'b0;
        dec = 1'b0;
        tog = 1'b0;
        if (kvalid) begin
            case (state)
                IDLE: begin
                    nstate = kdata == 8'hF0 ? BRK : kdata == 8'hE0 ? EXT : IDLE;
                    inc = kdata == 8'h79;
                    dec = kdata == 8'h7B;
                    tog = kdata == 8'h29;
`ifdef KBD_WASD_EN
                    dir_hit = kdata == 8'h1D || kdata == 8'h1B || kdata == 8'h1C || kdata == 8'h23;
                    dir = kdata == 8'h1D ? 2'd0 : kdata == 8'h1B ? 2'd1 : kdata == 8'h1C ? 2'd2 : 2'd3;
`endif
                end
                EXT: begin
                    nstate = kdata == 8'hF0 ? EXT_BRK : kdata == 8'hE0 ? EXT : IDLE;
                    dir_hit = kdata == 8'h75 || kdata == 8'h72 || kdata == 8'h6B || kdata == 8'h74;
                    dir = kdata == 8'h75 ? 2'd0 : kdata == 8'h72 ? 2'd1 : kdata == 8'h6B ? 2'd2 : 2'd3;
                end
                default: nstate = IDLE;
            endcase
        end
    end
    assign nlevel = inc ? (level == 3'd7 ? level : level + 3'd1)
                  : dec ? (level == 3'd0 ? level : level - 3'd1) : level;
    assign cmd_valid = count != 3'd0 && !paused;
    assign cmd = mem[rp];
    assign pop = cmd_valid && cmd_ready;
    assign push = dir_hit && !paused;
    assign full = count == 3'd4;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign accept = push && (!full || pop);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            level <= 3'(RESET_LEVEL);
            period <= PERIOD_BASE << (7 - RESET_LEVEL);
            paused <= 1'b0;
            overflow <= 1'b0;
            mem <= '0;
            wp <= 2'd0;
            rp <= 2'd0;
            count <= 3'd0;
        end else begin
            state <= nstate;
            level <= nlevel;
            period <= PERIOD_BASE << (3'd7 - nlevel);
            paused <= paused ^ tog;
            overflow <= overflow | (push && full && !pop);
            if (accept) begin
                mem[wp] <= dir;
                wp <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            count <= count + 3'(accept) - 3'(pop);
        end
    end
endmodule

// File: tb/tb_kbd_ctrl.sv
// tb_kbd_ctrl: directed scan-code stimulus with a queue scoreboard checking every popped command
module tb_kbd_ctrl;
    logic clk = 1'b0, reset = 1'b0, kvalid = 1'b0, cmd_ready = 1'b0;
    logic [7:0] kdata = 8'h00;
    logic [31:0] period;
    logic [1:0] cmd, e;
    logic cmd_valid, paused, overflow;
    int errors = 0, checks = 0;
    logic [1:0] exp_q[$];

    kbd_ctrl dut (
        .clk(clk), .reset(reset), .kdata(kdata), .kvalid(kvalid), .period(period),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .paused(paused),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b);
        kdata = b;
        kvalid = 1'b1;
        @(posedge clk);
        #1 kvalid = 1'b0;
    endtask

    task automatic arrow(input logic [7:0] b);
        send(8'hE0);
        send(b);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every handshake must match the oldest expected command
    always @(negedge clk) begin
        if (reset && cmd_valid && cmd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got cmd=%0d expected no entry", cmd);
            end else begin
                e = exp_q.pop_front();
                if (cmd !== e) begin
                    errors++;
                    $display("FAIL pop_order got cmd=%0d expected %0d", cmd, e);
                end
            end
        end
    end

    initial begin
        cycles(3);
        reset = 1'b1;
        cycles(2);
        chk("rst_period", period, 32'h0000_fff0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_paused", paused, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cmd", cmd, 0);

        arrow(8'h75);
        exp_q.push_back(2'd0);
        chk("up_valid", cmd_valid, 1);
        chk("up_cmd", cmd, 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        cmd_ready = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
        chk("single_entry", cmd_valid, 0);

        send(8'h79);
        chk("level4_period", period, 32'h0000_7ff8);
        repeat (4) send(8'h79);
        chk("level7_period", period, 32'h0000_0fff);
        repeat (8) send(8'h7B);
        chk("level0_period", period, 32'h0007_ff80);

        arrow(8'h75); arrow(8'h72); arrow(8'h6B); arrow(8'h74);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        chk("full_no_ovf", overflow, 0);
        arrow(8'h75);
        chk("ovf_set", overflow, 1);

        send(8'hE0);
        cmd_ready = 1'b1;
        send(8'h72);
        cmd_ready = 1'b0;
        exp_q.push_back(2'd1);
        chk("pushpop_ovf", overflow, 1);
        chk("pushpop_head", cmd, 1);
        arrow(8'h74);
        cmd_ready = 1'b1;
        cycles(4);
        cmd_ready = 1'b0;
        chk("drain_empty", cmd_valid, 0);

        arrow(8'h74);
        exp_q.push_back(2'd3);
        send(8'h29);
        chk("pause_on", paused, 1);
        chk("pause_gate", cmd_valid, 0);
        arrow(8'h6B);
        send(8'h29);
        chk("pause_off", paused, 0);
        chk("resume_valid", cmd_valid, 1);
        chk("resume_cmd", cmd, 3);
        cmd_ready = 1'b1;
        cycles(2);
        cmd_ready = 1'b0;
        chk("paused_drop", cmd_valid, 0);

        send(8'h1C);
`ifdef KBD_WASD_EN
        exp_q.push_back(2'd2);
        chk("wasd_valid", cmd_valid, 1);
        chk("wasd_cmd", cmd, 2);
        cmd_ready = 1'b1;
        cycles(1);
        cmd_ready = 1'b0;
`else
        chk("wasd_ignored", cmd_valid, 0);
`endif

        send(8'hE0);
        reset = 1'b0;
        cycles(2);
        chk("mid_rst_overflow", overflow, 0);
        reset = 1'b1;
        cycles(1);
        send(8'h75);
        chk("lone_75", cmd_valid, 0);
        chk("mid_rst_period", period, 32'h0000_fff0);

        cycles(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/kbd_ctrl.md
# kbd_ctrl

Keyboard command controller between the PS/2 `keyboard` receiver and the `lowclk`/`show` pair. It decodes the scan-code byte stream into make/break events and sets the `lowclk` tick period from a saturating 8-level speed setting. Direction commands go through a 4-entry FIFO with a valid/ready handshake to the display/game logic. Pause is a toggle that gates command delivery.

## Interface
- `PERIOD_BASE`, default 32'h0000_0fff: period unit; `period = PERIOD_BASE << (7 - level)`.
- `RESET_LEVEL`, default 3: speed level loaded at reset, 0..7.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `kdata`  in  8  received scan-code byte.
- `kvalid`  in  1  one-cycle strobe; `kdata` is valid in that cycle.
- `period`  out  32  tick period to `lowclk`, registered.
- `cmd`  out  2  head command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- `cmd_valid`  out  1  head entry available and not paused.
- `cmd_ready`  in  1  consumer accepts the head entry when high together with `cmd_valid`.
- `paused`  out  1  pause state.
- `overflow`  out  1  sticky flag, set when a command is dropped because the FIFO is full.

## Operation
- Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). The FSM advances only on `kvalid`.
- IDLE: F0→BRK; E0→EXT; any other byte is a make code, decoded with the non-extended map, then stay in IDLE.
- EXT: F0→EXT_BRK; E0→EXT; any other byte is an extended make code, decoded with the extended map, then →IDLE.
- BRK and EXT_BRK: the next byte, whatever its value, is consumed silently, then →IDLE. Break codes take no action.
- Extended map: 75 UP, 72 DOWN, 6B LEFT, 74 RIGHT.
- Non-extended map: 79 (keypad +) sets level+1, saturating at 7. 7B (keypad −) sets level−1, saturating at 0. 29 (space) toggles `paused`. With the macro enabled, WASD also maps: 1D UP, 1B DOWN, 1C LEFT, 23 RIGHT.
- Unmapped codes are ignored. Typematic repeats are repeated makes and each one acts again.
- A direction command is enqueued unless `paused` is high, in which case it is discarded without setting `overflow`.
- FIFO: 4 entries, 2-bit read and write pointers that wrap, 3-bit count 0..4.
- Pop occurs when `cmd_valid && cmd_ready`.
- Push while count==4 with no pop in the same cycle: command dropped, `overflow` set to 1.
- Push and pop in the same cycle while full: push accepted, count stays 4.
- Push and pop in the same cycle while empty: push is written; no pop occurs, because `cmd_valid` was 0.
- `cmd_valid = (count != 0) && !paused`. While paused, FIFO contents are held, not flushed.
- `overflow` clears only on reset.
- Reset values: FSM IDLE, level = RESET_LEVEL, `period` = PERIOD_BASE << (7 − RESET_LEVEL) = 32'h0000_fff0 at defaults, FIFO empty, `cmd_valid` 0, `cmd` 0, `paused` 0, `overflow` 0.
- Reset asserted mid-sequence (for example after E0): all state returns to reset values immediately and the partial sequence is lost.

## Timing
- `kvalid` byte in cycle N updates the FSM, level, `paused` and FIFO write at the clock edge ending cycle N.
- `cmd_valid`, `period` and `paused` reflect that byte in cycle N+1.
- `period` changes on the same edge as level; `lowclk` sees it one cycle after the code byte.
- `cmd` equals the head entry combinationally from FIFO storage. `cmd` is stable while `cmd_valid` is high and not popped.
- The block sustains back-to-back `kvalid` at one byte per cycle.

## Configuration
- `KBD_WASD_EN` defined: the WASD codes 1D/1B/1C/23 produce UP/DOWN/LEFT/RIGHT as well as the arrow keys.
- `KBD_WASD_EN` undefined: only the extended arrow codes produce commands; 1D/1B/1C/23 are ignored like any unmapped code.

## Test plan
- Reset, then idle: `period`=32'h0000_fff0, `cmd_valid`=0, `paused`=0, `overflow`=0.
- Bytes E0,75 then E0,F0,75 with `cmd_ready`=0: exactly one entry; `cmd`=0 and `cmd_valid`=1 from the cycle after 75; the break sequence adds nothing.
- 79 five times: level saturates at 7, `period`=32'h0000_0fff. Then 7B eight times: level 0, `period`=32'h0007_ff80.
- Five arrow makes with `cmd_ready`=0: count reaches 4, `overflow`=1 after the fifth. Then `cmd_ready`=1: four pops in arrival order, `cmd_valid`=0 after the last.
- With the FIFO full, push and pop in the same cycle: count stays 4 and `overflow` is unchanged.
- Space pressed, then E0,6B, then space again: no enqueue while paused; an entry queued before the pause reappears on `cmd_valid` after the second space.
- With `KBD_WASD_EN` defined, byte 1C gives `cmd`=2. With it undefined, byte 1C leaves the FIFO empty.
- `reset` low between E0 and 75: after release, a lone 75 is ignored (stays in IDLE, no enqueue).
